// File: rtl/mat_mul_pkg.sv
// mat_mul_pkg: shared types and constant helpers for the matrix-multiply engine.
// Optional build macro consumed by mat_mac_unit: MAT_MUL_SATURATE_EN.
package mat_mul_pkg;

   typedef enum logic [1:0] {StIdle, StCompute, StFlush, StOut} state_e;

   // Wide enough to hold any clamp bound for DATA_WIDTH up to 64.
   localparam int unsigned SatWidth = 128;

   // Sum of DIM products of two signed DATA_WIDTH values never overflows this.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned dim_log);
      return 2 * data_width + dim_log;
   endfunction

   function automatic logic signed [SatWidth-1:0] sat_max(input int unsigned data_width);
      logic signed [SatWidth-1:0] one;
      one = SatWidth'(1);
      return (one <<< (data_width - 1)) - one;
   endfunction

   function automatic logic signed [SatWidth-1:0] sat_min(input int unsigned data_width);
      logic signed [SatWidth-1:0] one;
      one = SatWidth'(1);
      return -(one <<< (data_width - 1));
   endfunction

endpackage

// File: rtl/mat_mac_unit.sv
// mat_mac_unit: registered signed multiply-accumulate with clear, and result
// formatting to DATA_WIDTH (truncate, or clamp when MAT_MUL_SATURATE_EN is defined).
module mat_mac_unit
   import mat_mul_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ACC_WIDTH  = 66,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_aresetn,
   input  logic                  in_valid,
   input  logic                  in_clr,
   input  logic                  in_last,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   output logic                  res_valid,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic [ADDR_WIDTH-1:0] res_addr
);

   logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
   logic signed [ACC_WIDTH-1:0]    prod_ext, acc_d, acc_q;

   // Sign-extend operands and product so the sum stays exact.
   always_comb begin
      a_ext    = {{DATA_WIDTH{in_a[DATA_WIDTH-1]}}, in_a};
      b_ext    = {{DATA_WIDTH{in_b[DATA_WIDTH-1]}}, in_b};
      prod     = a_ext * b_ext;
      prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      acc_d    = (in_clr ? '0 : acc_q) + prod_ext;
   end

   // Accumulator and result-strobe registers; res_valid marks the k-last product.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         acc_q     <= '0;
         res_valid <= 1'b0;
         res_addr  <= '0;
      end else begin
         res_valid <= in_valid && in_last;
         if (in_valid) begin
            acc_q    <= acc_d;
            res_addr <= in_addr;
         end
      end
   end

`ifdef MAT_MUL_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] AccMax = ACC_WIDTH'(sat_max(DATA_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] AccMin = ACC_WIDTH'(sat_min(DATA_WIDTH));

   // Clamp the accumulator into the signed DATA_WIDTH range.
   always_comb begin
      if (acc_q > AccMax)      res_data = AccMax[DATA_WIDTH-1:0];
      else if (acc_q < AccMin) res_data = AccMin[DATA_WIDTH-1:0];
      else                     res_data = acc_q[DATA_WIDTH-1:0];
   end
`else
   // Plain truncation to the low DATA_WIDTH bits.
   always_comb begin
      res_data = acc_q[DATA_WIDTH-1:0];
   end
`endif

endmodule

// File: rtl/mat_mul_stream.sv
// mat_mul_stream: AXI-Stream R = A x B engine with single-MAC sequential compute.
// Build option: define MAT_MUL_SATURATE_EN to clamp results instead of truncating.
module mat_mul_stream
   import mat_mul_pkg::*;
#(
   parameter int unsigned DIM_LOG    = 2,
   parameter int unsigned DIM        = 2 ** DIM_LOG,
   parameter int unsigned SIZE       = DIM * DIM,
   parameter int unsigned SIZE_LOG   = 2 * DIM_LOG,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, DIM_LOG)
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_aresetn,
   output logic                    s00_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                    s00_axis_tlast,
   input  logic                    s00_axis_tvalid,
   output logic                    m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tlast,
   input  logic                    m00_axis_tready,
   input  logic                    sel,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    frame_err
);

   localparam int unsigned TW = SIZE_LOG + DIM_LOG;
   localparam int unsigned CW = SIZE_LOG + 1;
   localparam logic [CW-1:0] SizeC   = CW'(SIZE);
   localparam logic [CW-1:0] SizeM1  = CW'(SIZE - 1);
   localparam logic [TW-1:0] TLast   = TW'(SIZE * DIM - 1);
   localparam logic [DIM_LOG-1:0] KLast = DIM_LOG'(DIM - 1);

   state_e state_q, state_d;
   logic rdy_q, sel_q, fl_q, done_q, frame_err_q;
   logic [CW-1:0] wcnt_q, rd_ptr_q;
   logic [TW-1:0] t_q;
   logic [DATA_WIDTH-1:0] a_mem [SIZE];
   logic [DATA_WIDTH-1:0] b_mem [SIZE];
   logic [DATA_WIDTH-1:0] r_mem [SIZE];
   logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q, pf_data_q, tdata_q, res_data;
   logic s1_valid_q, s1_clr_q, s1_last_q, res_valid;
   logic [SIZE_LOG-1:0] s1_raddr_q, res_addr;
   logic pf_valid_q, pf_last_q, tvalid_q, tlast_q;
   logic compute_en, flush_en, out_en;
   logic fire, first, tgt_b, wr_en, start_ok, t_last;
   logic hs, pf_take, pf_load, last_hs;
   logic [DIM_LOG-1:0] idx_i, idx_j, idx_k;

   // FSM state register.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) state_q <= StIdle;
      else                  state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start_ok) state_d = StCompute;
         StCompute: if (t_last)   state_d = StFlush;
         StFlush:   if (fl_q)     state_d = StOut;
         StOut:     if (last_hs)  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // FSM outputs; tready waits one clock after reset release via rdy_q.
   always_comb begin
      busy            = 1'b1;
      s00_axis_tready = 1'b0;
      compute_en      = 1'b0;
      flush_en        = 1'b0;
      out_en          = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy            = 1'b0;
            s00_axis_tready = rdy_q;
         end
         StCompute: compute_en = 1'b1;
         StFlush:   flush_en   = 1'b1;
         StOut:     out_en     = 1'b1;
         default:   busy       = 1'b1;
      endcase
   end

   // Load, start qualification and compute-index decode.
   always_comb begin
      fire     = s00_axis_tvalid && s00_axis_tready;
      first    = (wcnt_q == '0);
      tgt_b    = first ? sel : sel_q;
      wr_en    = fire && (wcnt_q < SizeC);
      // A beat in flight only lets start through if it closes the frame.
      start_ok = start && s00_axis_tready && (fire ? s00_axis_tlast : first);
      t_last   = (t_q == TLast);
      idx_i    = t_q[TW-1 -: DIM_LOG];
      idx_j    = t_q[SIZE_LOG-1 -: DIM_LOG];
      idx_k    = t_q[DIM_LOG-1:0];
   end

   // Control registers for loading, compute index and flush.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         rdy_q       <= 1'b0;
         wcnt_q      <= '0;
         sel_q       <= 1'b0;
         frame_err_q <= 1'b0;
         t_q         <= '0;
         fl_q        <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_clr_q    <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_raddr_q  <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (fire && first) sel_q <= sel;
         if (fire && s00_axis_tlast) begin
            wcnt_q      <= '0;
            frame_err_q <= (wcnt_q != SizeM1);
         end else if (fire) begin
            if (first)           frame_err_q <= 1'b0;
            if (wcnt_q < SizeC)  wcnt_q      <= wcnt_q + CW'(1);
         end
         if (compute_en) t_q <= t_last ? '0 : t_q + TW'(1);
         if (flush_en)   fl_q <= ~fl_q;
         s1_valid_q <= compute_en;
         s1_clr_q   <= (idx_k == '0);
         s1_last_q  <= (idx_k == KLast);
         s1_raddr_q <= {idx_i, idx_j};
      end
   end

   // Operand buffer A: stream write port, compute read port.
   always_ff @(posedge s00_axi_aclk) begin
      if (wr_en && !tgt_b) a_mem[wcnt_q[SIZE_LOG-1:0]] <= s00_axis_tdata;
      a_rd_q <= a_mem[{idx_i, idx_k}];
   end

   // Operand buffer B: stream write port, compute read port.
   always_ff @(posedge s00_axi_aclk) begin
      if (wr_en && tgt_b) b_mem[wcnt_q[SIZE_LOG-1:0]] <= s00_axis_tdata;
      b_rd_q <= b_mem[{idx_k, idx_j}];
   end

   mat_mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .ADDR_WIDTH (SIZE_LOG)
   ) u_mac (
      .s00_axi_aclk    (s00_axi_aclk),
      .s00_axi_aresetn (s00_axi_aresetn),
      .in_valid        (s1_valid_q),
      .in_clr          (s1_clr_q),
      .in_last         (s1_last_q),
      .in_a            (a_rd_q),
      .in_b            (b_rd_q),
      .in_addr         (s1_raddr_q),
      .res_valid       (res_valid),
      .res_data        (res_data),
      .res_addr        (res_addr)
   );

   // Output handshake: prefetch slot refills whenever it is empty or being drained.
   always_comb begin
      hs      = tvalid_q && m00_axis_tready;
      pf_take = pf_valid_q && (!tvalid_q || m00_axis_tready);
      pf_load = out_en && (rd_ptr_q != SizeC) && (!pf_valid_q || pf_take);
      last_hs = hs && tlast_q;
   end

   // Result buffer R: MAC write port, prefetch read port.
   always_ff @(posedge s00_axi_aclk) begin
      if (res_valid) r_mem[res_addr] <= res_data;
      if (pf_load)   pf_data_q <= r_mem[rd_ptr_q[SIZE_LOG-1:0]];
   end

   // Prefetch flags and master output register.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         rd_ptr_q   <= '0;
         pf_valid_q <= 1'b0;
         pf_last_q  <= 1'b0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tdata_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= last_hs;
         if (last_hs)      rd_ptr_q <= '0;
         else if (pf_load) rd_ptr_q <= rd_ptr_q + CW'(1);
         if (pf_load) begin
            pf_valid_q <= 1'b1;
            pf_last_q  <= (rd_ptr_q == SizeM1);
         end else if (pf_take) begin
            pf_valid_q <= 1'b0;
         end
         if (pf_take) begin
            tvalid_q <= 1'b1;
            tdata_q  <= pf_data_q;
            tlast_q  <= pf_last_q;
         end else if (hs) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end
      end
   end

   assign m00_axis_tvalid = tvalid_q;
   assign m00_axis_tdata  = tdata_q;
   assign m00_axis_tlast  = tlast_q;
   assign m00_axis_tstrb  = '1;
   assign done            = done_q;
   assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_mat_mul_stream.sv
// tb_mat_mul_stream: scenario tasks with a result scoreboard for mat_mul_stream (DIM=2).
module tb_mat_mul_stream;

   localparam int unsigned Dim  = 2;
   localparam int unsigned Size = 4;
   localparam int unsigned Dw   = 32;

   logic            s00_axi_aclk    = 1'b0;
   logic            s00_axi_aresetn = 1'b0;
   logic            s00_axis_tready;
   logic [Dw-1:0]   s00_axis_tdata  = '0;
   logic            s00_axis_tlast  = 1'b0;
   logic            s00_axis_tvalid = 1'b0;
   logic            m00_axis_tvalid;
   logic [Dw-1:0]   m00_axis_tdata;
   logic [Dw/8-1:0] m00_axis_tstrb;
   logic            m00_axis_tlast;
   logic            m00_axis_tready = 1'b0;
   logic            sel   = 1'b0;
   logic            start = 1'b0;
   logic            busy, done, frame_err;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [Dw-1:0] a_mdl [Size];
   logic [Dw-1:0] b_mdl [Size];
   int            beat_idx = 0;
   logic [Dw-1:0] exp_q [$];

   always #5 s00_axi_aclk = ~s00_axi_aclk;

   mat_mul_stream #(
      .DIM_LOG    (1),
      .DATA_WIDTH (Dw)
   ) dut (
      .s00_axi_aclk    (s00_axi_aclk),
      .s00_axi_aresetn (s00_axi_aresetn),
      .s00_axis_tready (s00_axis_tready),
      .s00_axis_tdata  (s00_axis_tdata),
      .s00_axis_tlast  (s00_axis_tlast),
      .s00_axis_tvalid (s00_axis_tvalid),
      .m00_axis_tvalid (m00_axis_tvalid),
      .m00_axis_tdata  (m00_axis_tdata),
      .m00_axis_tstrb  (m00_axis_tstrb),
      .m00_axis_tlast  (m00_axis_tlast),
      .m00_axis_tready (m00_axis_tready),
      .sel             (sel),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .frame_err       (frame_err)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // One slave beat; the model only keeps the first Size beats of a frame.
   task automatic send_beat(input logic s, input logic [Dw-1:0] d, input logic l);
      int n = 0;
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = d;
      s00_axis_tlast  = l;
      sel             = s;
      while (s00_axis_tready !== 1'b1 && n < 50) begin
         @(posedge s00_axi_aclk); #1;
         n++;
      end
      if (s00_axis_tready !== 1'b1) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: tready=%b required 1", s00_axis_tready);
      end else begin
         if (beat_idx < Size) begin
            if (s) b_mdl[beat_idx] = d;
            else   a_mdl[beat_idx] = d;
         end
         beat_idx = l ? 0 : beat_idx + 1;
      end
      @(posedge s00_axi_aclk); #1;
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame4(input logic s, input logic [Dw-1:0] d0, input logic [Dw-1:0] d1,
                              input logic [Dw-1:0] d2, input logic [Dw-1:0] d3);
      send_beat(s, d0, 1'b0);
      send_beat(s, d1, 1'b0);
      send_beat(s, d2, 1'b0);
      send_beat(s, d3, 1'b1);
   endtask

   // Reference product from the operand model, pushed in row-major order.
   task automatic push_expected();
      for (int i = 0; i < Dim; i++) begin
         for (int j = 0; j < Dim; j++) begin
            longint        acc;
            logic [63:0]   acc_bits;
            logic [Dw-1:0] r;
            acc = 0;
            for (int k = 0; k < Dim; k++) begin
               acc += longint'($signed(a_mdl[i*Dim+k])) * longint'($signed(b_mdl[k*Dim+j]));
            end
            acc_bits = acc;
            r = acc_bits[Dw-1:0];
`ifdef MAT_MUL_SATURATE_EN
            if (acc > longint'(2147483647))            r = 32'h7FFF_FFFF;
            else if (acc < -longint'(2147483647) - 1)  r = 32'h8000_0000;
`endif
            exp_q.push_back(r);
         end
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge s00_axi_aclk); #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (m00_axis_tvalid !== 1'b1 && cyc < 100) begin
         @(posedge s00_axi_aclk); #1;
         cyc++;
      end
      if (m00_axis_tvalid !== 1'b1) begin
         tests_run++;
         tests_failed++;
         $display("FAIL wait_valid_timeout: tvalid=%b required 1", m00_axis_tvalid);
      end
   endtask

   // Drain up to max_pop beats; rnd selects 50% random tready.
   task automatic collect(input bit rnd, input int max_pop, output int cycles);
      int            popped  = 0;
      bit            stalled = 1'b0;
      bit            fin     = 1'b0;
      logic [Dw-1:0] pd = '0;
      logic          pl = 1'b0;
      logic [Dw-1:0] e;
      logic          e_last;
      cycles = 0;
      while (!fin) begin
         m00_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stalled) begin
            tests_run++;
            if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== pd || m00_axis_tlast !== pl) begin
               tests_failed++;
               $display("FAIL stall_stable: valid=%b data=%h last=%b required 1 %h %b",
                        m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, pd, pl);
            end
         end
         if (m00_axis_tvalid === 1'b1 && m00_axis_tready === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL extra_beat: data=%h required no beat", m00_axis_tdata);
               fin = 1'b1;
            end else begin
               e      = exp_q.pop_front();
               e_last = (exp_q.size() == 0);
               popped++;
               if (m00_axis_tdata !== e) begin
                  tests_failed++;
                  $display("FAIL beat%0d_data: got %h required %h", popped - 1, m00_axis_tdata, e);
               end
               tests_run++;
               if (m00_axis_tlast !== e_last) begin
                  tests_failed++;
                  $display("FAIL beat%0d_last: got %b required %b", popped - 1, m00_axis_tlast,
                           e_last);
               end
               if (e_last || popped == max_pop) fin = 1'b1;
            end
         end
         stalled = (m00_axis_tvalid === 1'b1) && (m00_axis_tready !== 1'b1);
         pd      = m00_axis_tdata;
         pl      = m00_axis_tlast;
         if (!fin) begin
            cycles++;
            if (cycles > 200) begin
               tests_run++;
               tests_failed++;
               $display("FAIL collect_timeout: %0d beats left, required 0", exp_q.size());
               fin = 1'b1;
            end else begin
               @(posedge s00_axi_aclk); #1;
            end
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge s00_axi_aclk);
      #1;
      tests_run++;
      if (s00_axis_tready !== 1'b0) begin tests_failed++; $display("FAIL rst_tready: got %b required 0", s00_axis_tready); end
      tests_run++;
      if (m00_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_tvalid: got %b required 0", m00_axis_tvalid); end
      tests_run++;
      if (m00_axis_tlast !== 1'b0) begin tests_failed++; $display("FAIL rst_tlast: got %b required 0", m00_axis_tlast); end
      tests_run++;
      if (m00_axis_tdata !== '0) begin tests_failed++; $display("FAIL rst_tdata: got %h required 0", m00_axis_tdata); end
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_status: busy=%b done=%b err=%b required 0 0 0", busy, done, frame_err);
      end
      tests_run++;
      if (m00_axis_tstrb !== 4'hF) begin tests_failed++; $display("FAIL tstrb: got %h required f", m00_axis_tstrb); end
      s00_axi_aresetn = 1'b1;
      #1;
      tests_run++;
      if (s00_axis_tready !== 1'b0) begin tests_failed++; $display("FAIL rel_tready_early: got %b required 0", s00_axis_tready); end
      @(posedge s00_axi_aclk); #1;
      tests_run++;
      if (s00_axis_tready !== 1'b1) begin tests_failed++; $display("FAIL rel_tready: got %b required 1", s00_axis_tready); end
   endtask

   task automatic test_basic();
      int cyc;
      send_frame4(1'b0, 1, 2, 3, 4);
      send_frame4(1'b1, 5, 6, 7, 8);
      push_expected();
      m00_axis_tready = 1'b1;
      do_start();
      tests_run++;
      if (busy !== 1'b1 || s00_axis_tready !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_busy: busy=%b tready=%b required 1 0", busy, s00_axis_tready);
      end
      wait_valid(cyc);
      tests_run++;
      if (cyc != Size * Dim + 4) begin tests_failed++; $display("FAIL basic_latency: got %0d required %0d", cyc, Size * Dim + 4); end
      collect(1'b0, Size, cyc);
      tests_run++;
      if (cyc != Size - 1) begin tests_failed++; $display("FAIL basic_back_to_back: got %0d required %0d", cyc, Size - 1); end
      @(posedge s00_axi_aclk); #1;
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0 || m00_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_done: done=%b busy=%b tvalid=%b required 1 0 0", done, busy, m00_axis_tvalid);
      end
      @(posedge s00_axi_aclk); #1;
      tests_run++;
      if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: got %b required 0", done); end
   endtask

   task automatic test_signed();
      int cyc;
      send_frame4(1'b0, -1, 2, 3, -4);
      send_frame4(1'b1, 5, -6, -7, 8);
      push_expected();
      do_start();
      wait_valid(cyc);
      collect(1'b0, Size, cyc);
      @(posedge s00_axi_aclk); #1;
   endtask

   task automatic test_overflow();
      int cyc;
      send_frame4(1'b0, 32'h7FFF_FFFF, 0, 0, 32'h7FFF_FFFF);
      send_frame4(1'b1, 2, 0, 0, 2);
      push_expected();
      do_start();
      wait_valid(cyc);
      collect(1'b0, Size, cyc);
      @(posedge s00_axi_aclk); #1;
   endtask

   task automatic test_backpressure();
      int cyc;
      send_frame4(1'b0, 1, 2, 3, 4);
      send_frame4(1'b1, 5, 6, 7, 8);
      push_expected();
      do_start();
      wait_valid(cyc);
      collect(1'b1, Size, cyc);
      m00_axis_tready = 1'b1;
      @(posedge s00_axi_aclk); #1;
      tests_run++;
      if (done !== 1'b1) begin tests_failed++; $display("FAIL bp_done: got %b required 1", done); end
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL bp_drop: %0d left required 0", exp_q.size()); end
   endtask

   task automatic test_frame_err();
      int cyc;
      send_frame4(1'b1, 1, 0, 0, 1);
      tests_run++;
      if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL full_frame_err: got %b required 0", frame_err); end
      send_frame4(1'b0, 10, 20, 30, 40);
      send_beat(1'b0, 100, 1'b0);
      send_beat(1'b0, 101, 1'b0);
      send_beat(1'b0, 102, 1'b1);
      tests_run++;
      if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL short_err: got %b required 1", frame_err); end
      push_expected();
      do_start();
      wait_valid(cyc);
      collect(1'b0, Size, cyc);
      @(posedge s00_axi_aclk); #1;
      send_beat(1'b0, 1, 1'b0);
      tests_run++;
      if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b required 0", frame_err); end
      send_beat(1'b0, 2, 1'b0);
      send_beat(1'b0, 3, 1'b0);
      send_beat(1'b0, 4, 1'b0);
      send_beat(1'b0, 5, 1'b0);
      send_beat(1'b0, 6, 1'b1);
      tests_run++;
      if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL long_err: got %b required 1", frame_err); end
      push_expected();
      do_start();
      wait_valid(cyc);
      collect(1'b0, Size, cyc);
      @(posedge s00_axi_aclk); #1;
   endtask

   task automatic test_start_holdoff();
      int cyc;
      send_beat(1'b1, 5, 1'b0);
      start = 1'b1;
      send_beat(1'b1, 6, 1'b0);
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL holdoff_partial: busy=%b required 0", busy); end
      send_beat(1'b1, 7, 1'b0);
      send_beat(1'b1, 8, 1'b1);
      start = 1'b0;
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL holdoff_tlast_start: busy=%b required 1", busy); end
      push_expected();
      wait_valid(cyc);
      collect(1'b0, Size, cyc);
      @(posedge s00_axi_aclk); #1;
   endtask

   task automatic test_reset_mid();
      int cyc;
      push_expected();
      do_start();
      wait_valid(cyc);
      collect(1'b0, 2, cyc);
      @(posedge s00_axi_aclk); #1;
      s00_axi_aresetn = 1'b0;
      #1;
      tests_run++;
      if (m00_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: tvalid=%b busy=%b required 0 0", m00_axis_tvalid, busy);
      end
      exp_q.delete();
      #2;
      s00_axi_aresetn = 1'b1;
      @(posedge s00_axi_aclk); #1;
      push_expected();
      do_start();
      wait_valid(cyc);
      tests_run++;
      if (cyc != Size * Dim + 4) begin tests_failed++; $display("FAIL rerun_latency: got %0d required %0d", cyc, Size * Dim + 4); end
      collect(1'b0, Size, cyc);
      @(posedge s00_axi_aclk); #1;
      tests_run++;
      if (done !== 1'b1) begin tests_failed++; $display("FAIL rerun_done: got %b required 1", done); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_overflow();
      test_backpressure();
      test_frame_err();
      test_start_holdoff();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mat_mul_stream.md
# mat_mul_stream

Parametrised AXI-Stream matrix-multiply engine computing R = A × B for signed DIM×DIM integer matrices. Operands are loaded over the slave stream into two on-chip buffers, with `sel` choosing the target. A `start` pulse from the AXI-Lite register file launches a single-MAC sequential compute. R is then streamed out over the master port with full backpressure support.

## Interface
Parameters:
- DIM_LOG, 2 — log2 of matrix dimension (1..5)
- DIM, 2**DIM_LOG — matrix dimension
- SIZE, DIM*DIM — elements per matrix
- SIZE_LOG, 2*DIM_LOG — element address width
- DATA_WIDTH, 32 — element width, signed two's complement
- ACC_WIDTH, 2*DATA_WIDTH+DIM_LOG — accumulator width; never overflows

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset; s00_axi_aresetn, asynchronous, active-low; clock s00_axi_aclk
- s00_axis_tready  out  1  slave ready
- s00_axis_tdata  in  DATA_WIDTH  operand element, row-major
- s00_axis_tlast  in  1  last element of operand frame
- s00_axis_tvalid  in  1  slave valid
- m00_axis_tvalid  out  1  result valid
- m00_axis_tdata  out  DATA_WIDTH  result element, row-major
- m00_axis_tstrb  out  DATA_WIDTH/8  constant all ones
- m00_axis_tlast  out  1  asserted on element SIZE-1
- m00_axis_tready  in  1  master ready
- sel  in  1  load target: 0 = A, 1 = B; sampled on the first beat of each frame
- start  in  1  compute request; level sampled, acted on once per IDLE visit
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last result beat handshakes
- frame_err  out  1  sticky: last frame was short or long; cleared by the next frame's first beat

## Operation
- States: IDLE, COMPUTE, FLUSH, OUT.
- IDLE:
  - s00_axis_tready=1. Each accepted beat is written to A or B at the word counter, then the counter increments.
  - The frame ends on tlast. Counter and sel-latch reset.
  - Short frame (tlast before SIZE beats): unwritten entries keep old contents; frame_err=1.
  - Long frame: beats ≥ SIZE are accepted and discarded until tlast; frame_err=1.
- Start: honoured in IDLE only when the word counter is 0 (no partial frame). Otherwise it is held off until the frame ends. A beat with tlast accepted in the same cycle as start completes first; then IDLE→COMPUTE and tready drops the next cycle.
- COMPUTE:
  - Index t = 0..SIZE*DIM-1 steps once per cycle as (i,j,k) with k fastest.
  - Read addresses: A[i*DIM+k], B[k*DIM+j].
  - Buffer read latency is 1 cycle. The MAC clears on k=0 and accumulates the signed product.
  - The accumulator, formatted to DATA_WIDTH, is written to R[i*DIM+j] when the k=DIM-1 product completes.
- FLUSH: 2 cycles draining the read/MAC pipeline, then →OUT.
- OUT:
  - R is read with a one-entry prefetch register.
  - tdata and tlast are held stable while tvalid && !tready.
  - Advance only on handshake.
  - After beat SIZE-1 handshakes: done=1 for one cycle, →IDLE.
- Output format: low DATA_WIDTH bits of the accumulator (truncation), unless MAT_MUL_SATURATE_EN is defined.
- start and stream beats arriving outside IDLE are ignored; tready=0 there.

## Timing
- Reset values:
  - tready=0, then 1 on the first clock after deassertion.
  - m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0.
  - busy=0, done=0, frame_err=0.
  - State IDLE, all counters 0.
  - Buffer contents are not cleared.
- Reset mid-operation: immediate return to IDLE. Any partially streamed result is abandoned; tvalid drops asynchronously.
- Latency:
  - busy rises the cycle after start is sampled.
  - First m00_axis_tvalid is exactly SIZE*DIM+4 cycles after the start-sampling edge, for DIM=2.
  - With m00_axis_tready held high, beats are back-to-back: one per cycle, SIZE cycles.
- Throughput: one MAC per cycle, no bubbles inside COMPUTE.

## Configuration
- MAT_MUL_SATURATE_EN defined: each result is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before the R write.
- Undefined: plain truncation to the low DATA_WIDTH bits.
- Latency is identical in both builds.

## Structure
- Package mat_mul_pkg holds:
  - the state enumeration;
  - the ACC_WIDTH derivation function;
  - saturation min/max constant functions of DATA_WIDTH.
- Sub-module mat_mac_unit: registered signed multiply-accumulate with clear, k-last flag and output formatting (truncate/saturate).
- The three buffers are inferred simple-dual-port arrays in the top.

## Test plan
- DIM_LOG=1; load A=[1 2;3 4] (sel=0), B=[5 6;7 8] (sel=1); start → output stream 19,22,43,50; tlast on 50; done pulse; first tvalid 12 cycles after start.
- Signed values: A=[-1 2;3 -4], B=[5 -6;-7 8] → -19,22,43,-50.
- A=0x7FFFFFFF·I, B=2·I → 0xFFFFFFFE,0,0,0xFFFFFFFE without the macro; 0x7FFFFFFF,0,0,0x7FFFFFFF with MAT_MUL_SATURATE_EN.
- Random m00_axis_tready (50% duty) → tdata stable while stalled, four beats in order, no duplicates or drops.
- 3-beat A frame with tlast → frame_err=1, A[3] keeps its old value. A 6-beat frame → frame_err=1, extra beats discarded.
- Reset asserted after the second output beat → tvalid=0 immediately, busy=0; a re-run with the same start yields the full correct stream.
